// File: rtl/clock_reset_sequencer_pkg.sv
// Shared definitions for the clock/reset sequencer: state encoding and
// the counter width helper.
package clock_reset_sequencer_pkg;

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD    = S_HOLD,
    ST_RELEASE = S_RELEASE,
    ST_RUN     = S_RUN
  } state_t;

  // Wide enough for either the hold or the stagger count, with headroom so it never wraps.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_reset_synchronizer.sv
// Multi-flop synchroniser with asynchronous set/clear. RESET_VALUE=1 with d=0
// gives an async-assert/sync-deassert reset; RESET_VALUE=0 is a plain synchroniser.
module reset_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Board clock/reset front end: staggered per-domain reset release after a
// power-on hold, plus a divider / single-step clock-enable.
//
// state      | meaning
// HOLD       | all domains in reset, counting hold cycles
// RELEASE    | domains released one by one, STAGGER_CYCLES apart
// RUN        | all domains out of reset, ready=1
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 65535,
  parameter int STAGGER_CYCLES = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int DIV_WIDTH      = 24,
  parameter int DIV_RESET      = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   sw_reset_req,
  input  logic                   div_load,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic                   step_mode,
  input  logic                   step_in,
  output logic [NUM_DOMAINS-1:0] resetn,
  output logic                   ce,
  output logic                   ready
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

  logic                 rst_sync;
  logic                 step_sync;
  logic                 step_prev;
  logic                 mode_q;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] phase;

  reset_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_rst_sync (
    .clk  (CLK),
    .arst (RESET),
    .d    (1'b0),
    .q    (rst_sync)
  );

  reset_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (1'b0)
  ) u_step_sync (
    .clk  (CLK),
    .arst (rst_sync),
    .d    (step_in),
    .q    (step_sync)
  );

  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      idx    <= '0;
      resetn <= '0;
      ready  <= 1'b0;
    end else if (sw_reset_req) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      idx    <= '0;
      resetn <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state  <= ST_RELEASE;
            cnt    <= '0;
            idx    <= '0;
            resetn <= NUM_DOMAINS'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          // resetn is a thermometer code: each release shifts in one more 1
          if (idx == IDX_LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else if (cnt == STAGGER_LAST) begin
            cnt    <= '0;
            idx    <= idx + IDX_W'(1);
            resetn <= (resetn << 1) | NUM_DOMAINS'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  // ce is only produced while the current state is RELEASE/RUN and no
  // re-sequence is requested; any load or mode switch restarts the phase.
  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      div       <= DIV_WIDTH'(DIV_RESET);
      phase     <= '0;
      ce        <= 1'b0;
      step_prev <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      step_prev <= step_sync;
      mode_q    <= step_mode;
      if (div_load) begin
        div <= div_value;
      end
      if ((state == ST_HOLD) || sw_reset_req || div_load || (step_mode != mode_q)) begin
        phase <= '0;
        ce    <= 1'b0;
      end else if (step_mode) begin
        phase <= '0;
        ce    <= step_sync & ~step_prev;
      end else if (phase == div) begin
        phase <= '0;
        ce    <= 1'b1;
      end else begin
        phase <= phase + DIV_WIDTH'(1);
        ce    <= 1'b0;
      end
    end
  end

endmodule
